mlp_result_writer: RTL

Parametrised output stage of the MNIST MLP accelerator, sitting between the final-layer score stream and the output buffer (y_buf). Per run it accepts IMG_NUM × CLASS_NUM signed class scores and writes either every raw score or the per-image argmax class index into y_buf at a byte-address stride. On completion it raises a one-cycle done interrupt and a sticky done LED. Compared with the fixed 10-image output path, it generalises image count, class count, score width and address stride, and adds a run-time argmax mode.

---
 rtl/mlp_result_writer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mlp_result_writer.sv
// Output stage of the MLP accelerator: takes the final-layer score stream and writes
// either every raw score or the per-image argmax index into y_buf, then signals done.
module mlp_result_writer #(
    parameter int IMG_NUM          = 10,
    parameter int CLASS_NUM        = 10,
    parameter int SCORE_BW         = 32,
    parameter int Y_BUF_DATA_WIDTH = 32,
    parameter int ADDR_STRIDE      = 4,
    parameter int Y_BUF_DEPTH      = IMG_NUM * CLASS_NUM * ADDR_STRIDE,
    parameter int AW               = $clog2(Y_BUF_DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic                          mode_i,
    input  logic                          score_valid_i,
    output logic                          score_ready_o,
    input  logic [SCORE_BW-1:0]           score_data_i,
    output logic                          y_buf_en,
    output logic                          y_buf_wr_en,
    output logic [AW-1:0]                 y_buf_addr,
    output logic [Y_BUF_DATA_WIDTH-1:0]   y_buf_data,
    output logic                          done_intr_o,
    output logic                          done_led_o
);

    localparam int CW = (CLASS_NUM > 1) ? $clog2(CLASS_NUM) : 1;
    localparam int IW = (IMG_NUM > 1) ? $clog2(IMG_NUM) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic                          mode_reg;
    logic [CW-1:0]                 cls_reg;
    logic [IW-1:0]                 img_reg;
    logic [AW-1:0]                 addr_reg;
    logic signed [SCORE_BW-1:0]    max_reg;
    logic [CW-1:0]                 idx_reg;

    logic                          wr_reg;
    logic [AW-1:0]                 out_addr_reg;
    logic [Y_BUF_DATA_WIDTH-1:0]   out_data_reg;
    logic                          intr_reg;
    logic                          led_reg;

    logic                          start_ok;
    logic                          xfer;
    logic                          last_cls;
    logic                          last_img;
    logic                          better;
    logic                          do_write;
    logic signed [SCORE_BW-1:0]    score_s;
    logic [CW-1:0]                 best_idx;
    logic signed [SCORE_BW-1:0]    best_val;
    logic [Y_BUF_DATA_WIDTH-1:0]   score_ext;
    logic [Y_BUF_DATA_WIDTH-1:0]   wr_data;

    assign start_ok = (state_reg == IDLE) && start_i;
    assign xfer     = (state_reg == RUN) && score_valid_i;
    assign last_cls = (cls_reg == CW'(CLASS_NUM - 1));
    assign last_img = (img_reg == IW'(IMG_NUM - 1));
    assign score_s  = score_data_i;

    // Class 0 always seeds the max; later classes need a strict win so ties keep the lowest index.
    assign better   = (cls_reg == '0) || (score_s > max_reg);
    assign best_idx = better ? cls_reg : idx_reg;
    assign best_val = better ? score_s : max_reg;

    assign do_write  = xfer && (!mode_reg || last_cls);
    assign score_ext = Y_BUF_DATA_WIDTH'(score_s);
    assign wr_data   = mode_reg ? Y_BUF_DATA_WIDTH'(best_idx) : score_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        score_ready_o = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                score_ready_o = 1'b1;
                if (xfer && last_cls && last_img) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_reg     <= 1'b0;
            cls_reg      <= '0;
            img_reg      <= '0;
            addr_reg     <= '0;
            max_reg      <= '0;
            idx_reg      <= '0;
            wr_reg       <= 1'b0;
            out_addr_reg <= '0;
            out_data_reg <= '0;
            intr_reg     <= 1'b0;
            led_reg      <= 1'b0;
        end else begin
            wr_reg   <= do_write;
            intr_reg <= (state_reg == DONE);

            if (state_reg == DONE) begin
                led_reg <= 1'b1;
            end else if (start_ok) begin
                led_reg <= 1'b0;
            end

            if (start_ok) begin
                mode_reg <= mode_i;
                cls_reg  <= '0;
                img_reg  <= '0;
                addr_reg <= '0;
                max_reg  <= '0;
                idx_reg  <= '0;
            end else if (xfer) begin
                if (last_cls) begin
                    cls_reg <= '0;
                    img_reg <= img_reg + 1'b1;
                    max_reg <= '0;
                    idx_reg <= '0;
                end else begin
                    cls_reg <= cls_reg + 1'b1;
                    max_reg <= best_val;
                    idx_reg <= best_idx;
                end
                // Output address/data hold their last value between writes.
                if (do_write) begin
                    out_addr_reg <= addr_reg;
                    out_data_reg <= wr_data;
                    addr_reg     <= addr_reg + AW'(ADDR_STRIDE);
                end
            end
        end
    end

    assign y_buf_wr_en = wr_reg;
    assign y_buf_en    = wr_reg;
    assign y_buf_addr  = out_addr_reg;
    assign y_buf_data  = out_data_reg;
    assign done_intr_o = intr_reg;
    assign done_led_o  = led_reg;

endmodule
